// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the serial-to-parallel receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shift_deser_pkg;

    // Frame state: waiting for a start-of-frame bit, or collecting bits
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Bit order, latched from the sof bit of each frame
    localparam logic DIR_MSB_FIRST = 1'b0;
    localparam logic DIR_LSB_FIRST = 1'b1;

endpackage : shift_deser_pkg

// File: rtl/deser_shift_core.sv
// Shift datapath: working shift register, bit counter and latched bit order.
// Latency: o_word/o_done are combinational from the bit being accepted this cycle.
// Backpressure: none; the top decides which bits are accepted.
module deser_shift_core
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_shift,
    input  logic             i_ser_in,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_word,
    output logic             o_done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dir;
    logic [WIDTH-1:0] w_next_shreg;

    // Next shift-register value; a start bit clears stale bits from an abandoned frame
    always_comb begin
        w_next_shreg = r_shreg;
        if (i_start) begin
            if (i_dir == DIR_LSB_FIRST) begin
                w_next_shreg = {i_ser_in, {(WIDTH-1){1'b0}}};
            end else begin
                w_next_shreg = {{(WIDTH-1){1'b0}}, i_ser_in};
            end
        end else if (i_shift) begin
            if (r_dir == DIR_LSB_FIRST) begin
                w_next_shreg = {i_ser_in, r_shreg[WIDTH-1:1]};
            end else begin
                w_next_shreg = {r_shreg[WIDTH-2:0], i_ser_in};
            end
        end
    end

    // The word is complete on the cycle its last bit enters, so the top can load it without a bubble
    assign o_done = i_shift && (r_cnt == LAST_CNT);
    assign o_word = w_next_shreg;

    // Shift register, counter and bit order state; gaps hold everything
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_dir   <= DIR_MSB_FIRST;
        end else if (i_start) begin
            r_shreg <= w_next_shreg;
            r_cnt   <= CNT_W'(1);
            r_dir   <= i_dir;
        end else if (i_shift) begin
            r_shreg <= w_next_shreg;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

endmodule : deser_shift_core

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver with one-entry valid/ready output register and sticky overrun.
// Latency: word appears on o_data_out/o_out_valid one cycle after its last bit is accepted.
// Backpressure: no input stall; a word completing while the output is full and not draining is dropped and flagged.
module shift_deserializer
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_ser_in,
    input  logic             i_ser_valid,
    input  logic             i_ser_sof,
    input  logic             i_dir,
    output logic [WIDTH-1:0] o_data_out,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_overrun,
    input  logic             i_clr_overrun,
    output logic             o_busy
);

    state_t           r_state;
    logic [WIDTH-1:0] r_data_out;
    logic             r_out_valid;
    logic             r_overrun;
    logic             r_busy;

    logic             w_start;
    logic             w_shift;
    logic             w_done;
    logic [WIDTH-1:0] w_word;
    logic             w_can_load;

    // A sof bit starts or restarts a frame in either state; plain bits only count mid-frame
    assign w_start    = i_ser_valid && i_ser_sof;
    assign w_shift    = i_ser_valid && !i_ser_sof && (r_state == SHIFT);
    assign w_can_load = !r_out_valid || i_out_ready;

    deser_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_start  (w_start),
        .i_shift  (w_shift),
        .i_ser_in (i_ser_in),
        .i_dir    (i_dir),
        .o_word   (w_word),
        .o_done   (w_done)
    );

    // Frame FSM with registered busy, output register and sticky overrun
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_data_out  <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= SHIFT;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_done) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // A load in the same cycle as a transfer keeps out_valid high
            if (w_done && w_can_load) begin
                r_data_out  <= w_word;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end

            // Dropping a word wins over a clear in the same cycle
            if (w_done && !w_can_load) begin
                r_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_data_out  = r_data_out;
    assign o_out_valid = r_out_valid;
    assign o_overrun   = r_overrun;
    assign o_busy      = r_busy;

endmodule : shift_deserializer

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-to-parallel receiver for the bit stream produced by the 4-bit universal shift register when it is operated in shift-left or shift-right mode. It collects WIDTH serial bits into a word, supporting MSB-first or LSB-first order, and presents the word on a parallel output. Completed words are handed to the consumer through a one-entry valid/ready output register, with sticky overrun detection. The block sits at the far end of a serial link, opposite the shift-register transmitter.

## Interface
- WIDTH, 4: word width in bits; legal values are WIDTH ≥ 2.
- clk  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- ser_in  input  1  serial data bit.
- ser_valid  input  1  qualifies ser_in; one bit is accepted per cycle when high.
- ser_sof  input  1  marks the first bit of a word; meaningful only when ser_valid=1.
- dir  input  1  bit order: 0 = MSB-first (shift-left source), 1 = LSB-first (shift-right source). Sampled only on a sof bit.
- data_out  output  WIDTH  assembled word.
- out_valid  output  1  data_out holds an unconsumed word.
- out_ready  input  1  consumer accepts the word; a transfer occurs when out_valid & out_ready.
- overrun  output  1  sticky flag: a completed word was dropped.
- clr_overrun  input  1  clears overrun.
- busy  output  1  a frame is in progress (state SHIFT).

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: frame in progress. Bit counter cnt has width $clog2(WIDTH+1); the working shift register is shreg.
- In IDLE:
  - ser_valid & ser_sof: capture the bit, latch dir, set cnt=1, go to SHIFT.
  - ser_valid & !ser_sof: bit is discarded.
- In SHIFT, for each ser_valid bit, cnt increments:
  - MSB-first: shreg ← {shreg[WIDTH-2:0], ser_in}.
  - LSB-first: shreg ← {ser_in, shreg[WIDTH-1:1]}.
  - Result: after WIDTH bits, shreg equals the transmitter's parallel word.
- A sof bit in SHIFT abandons the partial frame and restarts with that bit (cnt=1, dir re-latched). No flag is raised.
- ser_valid=0 cycles are gaps. State, cnt and shreg hold.
- Word completion happens on the cycle the WIDTH-th bit is accepted. The state returns to IDLE.
  - If the output register is empty, or out_ready=1 that cycle: load data_out and set out_valid.
  - Otherwise: drop the word, keep data_out unchanged, set overrun.
- out_valid clears on transfer, unless a new word loads in the same cycle; in that case it stays 1.
- overrun: set takes priority over clr_overrun in the same cycle. Only clr_overrun or reset clears it.
- Reset values: data_out=0, out_valid=0, overrun=0, busy=0, state=IDLE, cnt=0, shreg=0. Reset mid-frame discards the partial word and any held output word.

## Timing
- Latency: data_out/out_valid become valid the cycle after the last bit is accepted.
- Throughput: one word per WIDTH valid cycles. A sof bit may immediately follow a completing bit with no bubble.
- busy is high from the cycle after the sof bit until the cycle after the completing bit.
- data_out is stable while out_valid=1 and no transfer has occurred.

## Structure
- Package shift_deser_pkg holds:
  - the state enum (IDLE, SHIFT);
  - DIR_MSB_FIRST=1'b0 and DIR_LSB_FIRST=1'b1.
- Sub-module deser_shift_core contains shreg, cnt and the latched dir, and outputs word and done. The top level holds the FSM, output register and overrun logic.

## Test plan
All scenarios use WIDTH=4.
- MSB-first: bits 1,0,1,0 (sof on first, dir=0), out_ready=1 → data_out=4'b1010 and out_valid=1 exactly one cycle after the 4th bit; overrun=0.
- LSB-first: bits 0,0,1,1 (dir=1) → data_out=4'b1100.
- Overrun: out_ready=0; send frame 1010, then back-to-back frame 0101 → after the 2nd frame, overrun=1, data_out stays 4'b1010, out_valid=1. Pulse clr_overrun → overrun=0. Raise out_ready → out_valid=0 next cycle.
- Resync: bits 1,1 (sof on first), then a sof bit 0 followed by 1,1,0, dir=0 → single word 4'b0110; no overrun.
- Gaps and stray bits: non-sof bits in IDLE are ignored. Frame 1,0,0,1 with ser_valid=0 gaps between bits → 4'b1001. busy is high only during the frame.
- Reset mid-frame: after 2 bits of a frame, with out_valid=1 holding 4'b1010, assert reset for 1 cycle → all outputs 0. A following complete frame 0011 → 4'b0011.
